// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the data-memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arbState_t;

  typedef enum logic {
    PROC = 1'b0,
    DBG  = 1'b1
  } owner_t;

  localparam int CountWidth = 4;

endpackage

// File: rtl/wait_counter.sv
// rtl/wait_counter.sv - loadable down-counter with zero flag for multi-cycle resources
module wait_counter #(
  parameter int Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] loadValue,
  input  logic             dec,
  output logic             isZero
);

  logic [Width-1:0] count;

  // Load wins over decrement; the count saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign isZero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin sharing of the data-memory port
// between the processor pipeline and a debug/loader master
module mem_port_arbiter #(
  parameter int DataWidth  = 16,
  parameter int AddrWidth  = 16,
  parameter int MemLatency = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic [AddrWidth-1:0] MemAddr,
  input  logic [DataWidth-1:0] MemData,
  output logic [DataWidth-1:0] MemOutput,
  output logic                 ProcStall,
  input  logic                 DbgReq,
  input  logic                 DbgWe,
  input  logic [AddrWidth-1:0] DbgAddr,
  input  logic [DataWidth-1:0] DbgWData,
  output logic [DataWidth-1:0] DbgRData,
  output logic                 DbgAck,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic [DataWidth-1:0] mem_rdata
);

  import mem_arb_pkg::*;

  localparam logic [CountWidth-1:0] LoadCount = CountWidth'(MemLatency - 1);

  arbState_t            state;
  arbState_t            nextState;
  owner_t               ownerQ;
  owner_t               grantOwner;
  owner_t               lastGrant;
  logic                 weQ;
  logic [AddrWidth-1:0] addrQ;
  logic [DataWidth-1:0] wdataQ;
  logic                 procReq;
  logic                 grant;
  logic                 accessDone;
  logic                 cntZero;

  // A simultaneous read and write request is served as a write.
  assign procReq = MemRead | MemWrite;

  always_comb begin
    nextState  = state;
    grantOwner = PROC;
    grant      = 1'b0;
    accessDone = 1'b0;
    case (state)
      IDLE: begin
        if (procReq || DbgReq) begin
          grant     = 1'b1;
          nextState = ACCESS;
          if (procReq && DbgReq) begin
            grantOwner = (lastGrant == DBG) ? PROC : DBG;
          end else begin
            grantOwner = DbgReq ? DBG : PROC;
          end
        end
      end
      ACCESS: begin
        if (cntZero) begin
          accessDone = 1'b1;
          nextState  = DONE;
        end
      end
      DONE: begin
        nextState = IDLE;
      end
      default: begin
        nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      ownerQ    <= PROC;
      lastGrant <= DBG;
      weQ       <= 1'b0;
      addrQ     <= '0;
      wdataQ    <= '0;
      MemOutput <= '0;
      DbgRData  <= '0;
    end else begin
      state <= nextState;
      if (grant) begin
        ownerQ <= grantOwner;
        weQ    <= (grantOwner == DBG) ? DbgWe    : MemWrite;
        addrQ  <= (grantOwner == DBG) ? DbgAddr  : MemAddr;
        wdataQ <= (grantOwner == DBG) ? DbgWData : MemData;
      end
      if (accessDone) begin
        lastGrant <= ownerQ;
        if (!weQ) begin
          if (ownerQ == DBG) begin
            DbgRData <= mem_rdata;
          end else begin
            MemOutput <= mem_rdata;
          end
        end
      end
    end
  end

  // Counter is loaded at grant, so ACCESS lasts exactly MemLatency cycles.
  wait_counter #(
    .Width(CountWidth)
  ) accessTimer (
    .clk      (CLK),
    .rst      (RST),
    .load     (grant),
    .loadValue(LoadCount),
    .dec      (state == ACCESS),
    .isZero   (cntZero)
  );

  // Address/data buses are forced low outside an access so the memory sees quiet lines.
  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & weQ;
  assign mem_addr  = mem_en ? addrQ  : '0;
  assign mem_wdata = mem_en ? wdataQ : '0;
  assign DbgAck    = (state == DONE) && (ownerQ == DBG);
  assign ProcStall = procReq & ~((state == DONE) && (ownerQ == PROC));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int L = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        MemRead, MemWrite, DbgReq, DbgWe;
  logic [15:0] MemAddr, MemData, DbgAddr, DbgWData;
  logic [15:0] MemOutput, DbgRData, mem_addr, mem_wdata, mem_rdata;
  logic        ProcStall, DbgAck, mem_en, mem_we;

  logic [15:0] tbMem [256];
  logic [15:0] refMem [256];
  logic [15:0] expProcOut, expDbgOut;
  bit          modelLastDbg;
  int          checks = 0;
  int          failures = 0;

  mem_port_arbiter #(.DataWidth(16), .AddrWidth(16), .MemLatency(L)) dut (
    .CLK(CLK), .RST(RST),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemAddr(MemAddr), .MemData(MemData),
    .MemOutput(MemOutput), .ProcStall(ProcStall),
    .DbgReq(DbgReq), .DbgWe(DbgWe), .DbgAddr(DbgAddr), .DbgWData(DbgWData),
    .DbgRData(DbgRData), .DbgAck(DbgAck),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (mem_en && mem_we) tbMem[mem_addr[7:0]] <= mem_wdata;
  assign mem_rdata = tbMem[mem_addr[7:0]];

  task automatic doReset();
    @(negedge CLK);
    RST = 1'b1; MemRead = 0; MemWrite = 0; DbgReq = 0; DbgWe = 0;
    MemAddr = 0; MemData = 0; DbgAddr = 0; DbgWData = 0;
    @(negedge CLK);
    RST = 1'b0;
    modelLastDbg = 1'b1; expProcOut = 0; expDbgOut = 0;
  endtask

  task automatic applyProc(input bit we, input logic [15:0] a, input logic [15:0] d);
    if (we) refMem[a[7:0]] = d; else expProcOut = refMem[a[7:0]];
    modelLastDbg = 1'b0;
  endtask

  task automatic applyDbg(input bit we, input logic [15:0] a, input logic [15:0] d);
    if (we) refMem[a[7:0]] = d; else expDbgOut = refMem[a[7:0]];
    modelLastDbg = 1'b1;
  endtask

  // One round of requests from either or both masters, served to completion.
  task automatic runPair(input string tag, input bit pReq, input bit pRd, input bit pWr,
                         input logic [15:0] pAddr, input logic [15:0] pData,
                         input bit dReq, input bit dWe, input logic [15:0] dAddr,
                         input logic [15:0] dData, input bit scramble);
    logic [15:0] eAddr [32];
    logic [15:0] eWd [32];
    bit          eWe [32];
    bit          procFirst, procPend, dbgPend, pWe;
    int          nExp, idx, stalls, expProcAt, expDbgAt, s;
    pWe = pWr;
    procFirst = pReq && (!dReq || modelLastDbg);
    nExp = 0; idx = 0;
    for (int k = 0; k < 2; k++) begin
      bit takeProc;
      takeProc = (k == 0) ? procFirst : !procFirst;
      if (takeProc && pReq) begin
        for (int j = 0; j < L; j++) begin eAddr[nExp] = pAddr; eWd[nExp] = pData; eWe[nExp] = pWe; nExp++; end
      end else if (!takeProc && dReq) begin
        for (int j = 0; j < L; j++) begin eAddr[nExp] = dAddr; eWd[nExp] = dData; eWe[nExp] = dWe; nExp++; end
      end
    end
    expProcAt = procFirst ? L + 1 : 2 * L + 3;
    expDbgAt  = (pReq && procFirst) ? 2 * L + 3 : L + 1;
    @(negedge CLK);
    MemRead = pReq & pRd; MemWrite = pReq & pWr; MemAddr = pAddr; MemData = pData;
    DbgReq = dReq; DbgWe = dWe; DbgAddr = dAddr; DbgWData = dData;
    procPend = pReq; dbgPend = dReq;
    #1 stalls = ProcStall ? 1 : 0;
    for (s = 1; s <= 4 * L + 12 && (procPend || dbgPend); s++) begin
      @(negedge CLK);
      if (mem_en) begin
        checks++;
        if (idx >= nExp) begin
          failures++; $display("FAIL %s extra_mem_en: got addr %h expected no access", tag, mem_addr);
        end else if (mem_addr !== eAddr[idx] || mem_we !== eWe[idx] || (eWe[idx] && mem_wdata !== eWd[idx])) begin
          failures++;
          $display("FAIL %s mem_bus[%0d]: got addr=%h we=%b wd=%h expected addr=%h we=%b wd=%h",
                   tag, idx, mem_addr, mem_we, mem_wdata, eAddr[idx], eWe[idx], eWd[idx]);
        end
        idx++;
      end
      if (scramble) begin
        if ((procFirst && pReq) ? (s >= 1) : (s >= L + 3)) begin
          MemAddr = 16'($urandom); MemData = 16'($urandom);
        end
        if ((!procFirst || !pReq) ? (s >= 1) : (s >= L + 3)) begin
          DbgAddr = 16'($urandom); DbgWData = 16'($urandom); if (dbgPend) DbgWe = 1'($urandom);
        end
      end
      if (procPend) begin
        if (ProcStall) stalls++;
        else begin
          procPend = 1'b0; MemRead = 0; MemWrite = 0;
          applyProc(pWe, pAddr, pData);
          checks++;
          if (s != expProcAt || stalls != expProcAt) begin
            failures++; $display("FAIL %s proc_timing: got done=%0d stalls=%0d expected %0d", tag, s, stalls, expProcAt);
          end
          checks++;
          if (MemOutput !== expProcOut || DbgRData !== expDbgOut) begin
            failures++; $display("FAIL %s proc_rdata: got MemOutput=%h DbgRData=%h expected %h %h", tag, MemOutput, DbgRData, expProcOut, expDbgOut);
          end
        end
      end else if (ProcStall !== 1'b0) begin
        checks++; failures++; $display("FAIL %s stall_no_req: got %b expected 0", tag, ProcStall);
      end
      if (DbgAck) begin
        checks++;
        if (!dbgPend) begin
          failures++; $display("FAIL %s spurious_ack: got 1 expected 0", tag);
        end else begin
          dbgPend = 1'b0; DbgReq = 0;
          applyDbg(dWe, dAddr, dData);
          if (s != expDbgAt) begin
            failures++; $display("FAIL %s ack_timing: got %0d expected %0d", tag, s, expDbgAt);
          end
          checks++;
          if (DbgRData !== expDbgOut || MemOutput !== expProcOut) begin
            failures++; $display("FAIL %s dbg_rdata: got DbgRData=%h MemOutput=%h expected %h %h", tag, DbgRData, MemOutput, expDbgOut, expProcOut);
          end
        end
      end
    end
    checks++;
    if (procPend || dbgPend) begin
      failures++; $display("FAIL %s timeout: got pending=%b%b expected 00", tag, procPend, dbgPend);
      MemRead = 0; MemWrite = 0; DbgReq = 0;
    end
    checks++;
    if (idx != nExp) begin
      failures++; $display("FAIL %s access_cycles: got %0d expected %0d", tag, idx, nExp);
    end
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if ({mem_en, mem_we, mem_addr, mem_wdata, MemOutput, DbgRData, DbgAck, ProcStall} !== '0) begin
      failures++; $display("FAIL reset_outputs: got en=%b we=%b a=%h wd=%h mo=%h dr=%h ack=%b st=%b expected all 0",
                           mem_en, mem_we, mem_addr, mem_wdata, MemOutput, DbgRData, DbgAck, ProcStall);
    end
  endtask

  task automatic test_proc_read();
    runPair("proc_read", 1, 1, 0, 16'h0010, 16'h0000, 0, 0, 0, 0, 0);
    checks++;
    if (MemOutput !== 16'h00AB) begin
      failures++; $display("FAIL proc_read_value: got %h expected 00ab", MemOutput);
    end
  endtask

  task automatic test_dbg_write();
    runPair("dbg_write", 0, 0, 0, 0, 0, 1, 1, 16'h0020, 16'h1234, 0);
    checks++;
    if (DbgRData !== 16'h0000) begin
      failures++; $display("FAIL dbg_write_rdata: got %h expected 0000", DbgRData);
    end
  endtask

  task automatic test_read_write_both();
    runPair("rw_both", 1, 1, 1, 16'h0060, 16'h0015, 0, 0, 0, 0, 0);
    checks++;
    if (MemOutput !== 16'h00AB) begin
      failures++; $display("FAIL rw_both_output: got %h expected 00ab", MemOutput);
    end
  endtask

  task automatic test_input_change();
    runPair("input_change", 1, 1, 0, 16'h0010, 16'h0000, 0, 0, 0, 0, 1);
    runPair("input_change_dual", 1, 0, 1, 16'h0031, 16'h7777, 1, 0, 16'h0031, 16'h0, 1);
  endtask

  task automatic test_back_to_back();
    int p;
    doReset();
    p = L + 2;
    @(negedge CLK);
    MemRead = 1; MemAddr = 16'h0040; DbgReq = 1; DbgWe = 0; DbgAddr = 16'h0050;
    for (int k = 1; k <= 4 * p - 1; k++) begin
      int ph;
      bit isDbg, expEn, expStall, expAck;
      @(negedge CLK);
      ph = (k - 1) % p;
      isDbg = (((k - 1) / p) % 2) == 1;
      expEn = ph < L;
      expStall = !(ph == L && !isDbg);
      expAck = (ph == L) && isDbg;
      checks++;
      if (mem_en !== expEn || (expEn && mem_addr !== (isDbg ? 16'h0050 : 16'h0040))) begin
        failures++; $display("FAIL b2b_bus[%0d]: got en=%b addr=%h expected en=%b owner_dbg=%b", k, mem_en, mem_addr, expEn, isDbg);
      end
      checks++;
      if (ProcStall !== expStall || DbgAck !== expAck) begin
        failures++; $display("FAIL b2b_handshake[%0d]: got stall=%b ack=%b expected %b %b", k, ProcStall, DbgAck, expStall, expAck);
      end
      if (ph == L) begin
        if (isDbg) applyDbg(0, 16'h0050, 0); else applyProc(0, 16'h0040, 0);
      end
    end
    MemRead = 0; DbgReq = 0;
    @(negedge CLK);
    checks++;
    if (MemOutput !== expProcOut || DbgRData !== expDbgOut) begin
      failures++; $display("FAIL b2b_rdata: got %h %h expected %h %h", MemOutput, DbgRData, expProcOut, expDbgOut);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int kind, mode;
      kind = $urandom_range(0, 2);
      mode = $urandom_range(0, 2);
      runPair("random", kind != 1, mode != 1, mode != 0, 16'($urandom) & 16'hFF1F, 16'($urandom),
              kind != 0, 1'($urandom), 16'($urandom) & 16'hFF1F, 16'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end
  endtask

  task automatic test_reset_mid_access();
    runPair("pre_abort_read", 0, 0, 0, 0, 0, 1, 0, 16'h0077, 0, 0);
    @(negedge CLK);
    DbgReq = 1; DbgWe = 0; DbgAddr = 16'h0020;
    @(negedge CLK);
    checks++;
    if (mem_en !== 1'b1) begin
      failures++; $display("FAIL abort_in_access: got mem_en=%b expected 1", mem_en);
    end
    RST = 1'b1; DbgReq = 0;
    @(negedge CLK);
    RST = 1'b0;
    modelLastDbg = 1'b1; expProcOut = 0; expDbgOut = 0;
    checks++;
    if (mem_en !== 0 || DbgAck !== 0 || DbgRData !== 0 || MemOutput !== 0 || ProcStall !== 0) begin
      failures++; $display("FAIL abort_state: got en=%b ack=%b dr=%h mo=%h st=%b expected 0 0 0000 0000 0",
                           mem_en, DbgAck, DbgRData, MemOutput, ProcStall);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      checks++;
      if (DbgAck !== 0 || mem_en !== 0) begin
        failures++; $display("FAIL abort_quiet[%0d]: got ack=%b en=%b expected 0 0", k, DbgAck, mem_en);
      end
    end
    runPair("post_abort_tie", 1, 1, 0, 16'h0010, 0, 1, 0, 16'h0020, 0, 0);
  endtask

  initial begin
    RST = 1'b1; MemRead = 0; MemWrite = 0; DbgReq = 0; DbgWe = 0;
    MemAddr = 0; MemData = 0; DbgAddr = 0; DbgWData = 0;
    for (int i = 0; i < 256; i++) begin
      tbMem[i] = 16'(i * 16'h0101) ^ 16'h3C00;
      refMem[i] = tbMem[i];
    end
    tbMem[16'h10] = 16'h00AB;
    refMem[16'h10] = 16'h00AB;
    test_reset();
    test_proc_read();
    test_dbg_write();
    test_read_write_both();
    test_input_change();
    test_back_to_back();
    test_random();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
